// File: rtl/dw_reg_array.sv
// rtl/dw_reg_array.sv - per-row pixel window register array with per-lane reuse FIFOs
// Optional zero-padding input pad_en is enabled by defining DW_REG_ARRAY_ZPAD_EN.
module dw_reg_array #(
  parameter int POY        = 3,
  parameter int KSIZE      = 3,
  parameter int STRIDE     = 1,
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2*POY-1:0]          reg_array_cmd,
  input  logic [DW*POY-1:0]         buf_pix,
  input  logic                      fifo_read,
  input  logic                      dwpe_ena,
`ifdef DW_REG_ARRAY_ZPAD_EN
  input  logic [POY-1:0]            pad_en,
`endif
  output logic [DW*KSIZE*POY-1:0]   win_out,
  output logic                      win_valid,
  output logic [POY-1:0]            fq_empty,
  output logic                      err_ovf,
  output logic                      err_udf
);

  localparam int NF = POY - 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] CMD_IB = 2'b00;
  localparam logic [1:0] CMD_SF = 2'b01;
  localparam logic [1:0] CMD_IF = 2'b10;

  logic [DW-1:0] win     [POY][KSIZE];
  logic [DW-1:0] stg     [NF];
  logic [NF-1:0] stg_vld;
  logic [DW-1:0] fq_mem  [NF][FIFO_DEPTH];
  logic [AW:0]   wr_ptr  [NF];
  logic [AW:0]   rd_ptr  [NF];

  logic [POY-1:0] shift, rot, pad;
  logic [DW-1:0]  enter     [POY];
  logic [NF-1:0]  is_if, f_empty, f_full, pop, push_req, push_ok;
  logic [DW-1:0]  push_data [NF];
  logic           udf_hit, ovf_hit;

`ifdef DW_REG_ARRAY_ZPAD_EN
  assign pad = pad_en;
`else
  assign pad = '0;
`endif

  always_comb begin
    shift    = '0;
    rot      = '0;
    is_if    = '0;
    f_empty  = '0;
    f_full   = '0;
    pop      = '0;
    push_req = '0;
    push_ok  = '0;
    udf_hit  = 1'b0;
    ovf_hit  = 1'b0;
    for (int i = 0; i < POY; i++) begin
      shift[i] = (reg_array_cmd[2*i+:2] == CMD_IB) || (reg_array_cmd[2*i+:2] == CMD_IF);
      rot[i]   = (reg_array_cmd[2*i+:2] == CMD_SF);
      enter[i] = pad[i] ? '0 : buf_pix[DW*i+:DW];
    end
    // The last lane has no FIFO, so an IF there keeps the buffer pixel like IB.
    for (int j = 0; j < NF; j++) begin
      is_if[j] = (reg_array_cmd[2*j+:2] == CMD_IF);
      if (is_if[j]) begin
        if (pad[j]) begin
          enter[j] = '0;
        end else if (stg_vld[j]) begin
          enter[j] = stg[j];
        end else begin
          enter[j] = '0;
          udf_hit  = 1'b1;
        end
      end
    end
    for (int j = 0; j < NF; j++) push_data[j] = '0;
    for (int i = STRIDE; i < POY; i++) begin
      push_req[i-STRIDE]  = shift[i];
      push_data[i-STRIDE] = enter[i];
    end
    for (int j = 0; j < NF; j++) begin
      f_empty[j] = (wr_ptr[j] == rd_ptr[j]);
      f_full[j]  = (wr_ptr[j][AW] != rd_ptr[j][AW]) && (wr_ptr[j][AW-1:0] == rd_ptr[j][AW-1:0]);
      pop[j]     = fifo_read && !f_empty[j];
      push_ok[j] = push_req[j] && (!f_full[j] || pop[j]);
      if (push_req[j] && f_full[j] && !pop[j]) ovf_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < POY; i++)
        for (int k = 0; k < KSIZE; k++) win[i][k] <= '0;
      for (int j = 0; j < NF; j++) begin
        stg[j]    <= '0;
        wr_ptr[j] <= '0;
        rd_ptr[j] <= '0;
      end
      stg_vld   <= '0;
      win_valid <= 1'b0;
      err_ovf   <= 1'b0;
      err_udf   <= 1'b0;
    end else begin
      win_valid <= dwpe_ena;
      if (ovf_hit) err_ovf <= 1'b1;
      if (udf_hit) err_udf <= 1'b1;
      for (int i = 0; i < POY; i++) begin
        if (shift[i]) begin
          for (int k = 0; k < KSIZE-1; k++) win[i][k] <= win[i][k+1];
          win[i][KSIZE-1] <= enter[i];
        end else if (rot[i]) begin
          for (int k = 0; k < KSIZE; k++) win[i][k] <= win[i][(k+1)%KSIZE];
        end
      end
      // A pop in the same cycle as an IF refills staging after the IF consumed it.
      for (int j = 0; j < NF; j++) begin
        if (is_if[j]) stg_vld[j] <= 1'b0;
        if (pop[j]) begin
          stg[j]     <= fq_mem[j][rd_ptr[j][AW-1:0]];
          stg_vld[j] <= 1'b1;
          rd_ptr[j]  <= rd_ptr[j] + (AW+1)'(1);
        end
        if (push_ok[j]) wr_ptr[j] <= wr_ptr[j] + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < NF; j++)
      if (!rst && push_ok[j]) fq_mem[j][wr_ptr[j][AW-1:0]] <= push_data[j];
  end

  for (genvar gi = 0; gi < POY; gi++) begin : g_lane
    for (genvar gk = 0; gk < KSIZE; gk++) begin : g_slot
      assign win_out[DW*(gi*KSIZE+gk)+:DW] = win[gi][gk];
    end
  end

  assign fq_empty = {1'b1, f_empty};

endmodule

// File: tb/tb_dw_reg_array.sv
// tb/tb_dw_reg_array.sv - directed table-driven bench for dw_reg_array
module tb_dw_reg_array;
  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  cmd;
  logic [23:0] bp;
  logic        frd;
  logic        ena;
  logic [71:0] win_out;
  logic        win_valid;
  logic [2:0]  fq_empty;
  logic        err_ovf;
  logic        err_udf;

  int total = 0;
  int bad   = 0;

  dw_reg_array #(.POY(3), .KSIZE(3), .STRIDE(1), .DW(8), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .reg_array_cmd(cmd), .buf_pix(bp), .fifo_read(frd),
    .dwpe_ena(ena), .win_out(win_out), .win_valid(win_valid), .fq_empty(fq_empty),
    .err_ovf(err_ovf), .err_udf(err_udf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  cmd;
    logic [23:0] bp;
    logic        frd;
    logic        ena;
    logic [71:0] win;
    logic        vld;
    logic [2:0]  emp;
  } vec_t;

  vec_t tv [11];

  function automatic logic [71:0] w(input int a0, a1, a2, b0, b1, b2, c0, c1, c2);
    return {c2[7:0], c1[7:0], c0[7:0], b2[7:0], b1[7:0], b0[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endfunction

  function automatic logic [23:0] bp3(input int p0, p1, p2);
    return {p2[7:0], p1[7:0], p0[7:0]};
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] c, input logic [23:0] b, input logic f, input logic e);
    cmd = c; bp = b; frd = f; ena = e;
  endtask

  initial begin
    tv[0]  = '{6'b000000, bp3(1, 11, 21), 0, 0, w(0,0,1, 0,0,11, 0,0,21), 0, 3'b100};
    tv[1]  = '{6'b000000, bp3(2, 12, 22), 0, 0, w(0,1,2, 0,11,12, 0,21,22), 0, 3'b100};
    tv[2]  = '{6'b000000, bp3(3, 13, 23), 0, 0, w(1,2,3, 11,12,13, 21,22,23), 0, 3'b100};
    tv[3]  = '{6'b111101, 24'd0, 0, 0, w(2,3,1, 11,12,13, 21,22,23), 0, 3'b100};
    tv[4]  = '{6'b111111, 24'd0, 1, 0, w(2,3,1, 11,12,13, 21,22,23), 0, 3'b100};
    tv[5]  = '{6'b001010, bp3(0, 0, 31), 0, 1, w(3,1,11, 12,13,21, 22,23,31), 1, 3'b100};
    tv[6]  = '{6'b111111, 24'd0, 1, 0, w(3,1,11, 12,13,21, 22,23,31), 0, 3'b100};
    tv[7]  = '{6'b111010, 24'd0, 0, 0, w(1,11,12, 13,21,22, 22,23,31), 0, 3'b100};
    tv[8]  = '{6'b111111, 24'd0, 1, 0, w(1,11,12, 13,21,22, 22,23,31), 0, 3'b100};
    tv[9]  = '{6'b111111, 24'd0, 1, 0, w(1,11,12, 13,21,22, 22,23,31), 0, 3'b110};
    tv[10] = '{6'b101010, bp3(0, 0, 41), 0, 0, w(11,12,21, 21,22,31, 23,31,41), 0, 3'b100};

    rst = 1'b1;
    drive(6'b000000, 24'hA5A5A5, 1, 1);
    step;
    drive(6'b101010, 24'h5A5A5A, 1, 1);
    step;
    chk("reset_win", win_out, '0);
    chk("reset_vld", {71'd0, win_valid}, 72'd0);
    chk("reset_emp", {69'd0, fq_empty}, 72'd7);
    chk("reset_err", {70'd0, err_ovf, err_udf}, 72'd0);
    rst = 1'b0;

    for (int v = 0; v < 11; v++) begin
      drive(tv[v].cmd, tv[v].bp, tv[v].frd, tv[v].ena);
      step;
      chk($sformatf("v%0d_win", v), win_out, tv[v].win);
      chk($sformatf("v%0d_vld", v), {71'd0, win_valid}, {71'd0, tv[v].vld});
      chk($sformatf("v%0d_emp", v), {69'd0, fq_empty}, {69'd0, tv[v].emp});
      chk($sformatf("v%0d_err", v), {70'd0, err_ovf, err_udf}, 72'd0);
    end

    drive(6'b111110, 24'd0, 0, 0);
    step;
    chk("udf_lane0", {48'd0, win_out[23:0]}, {48'd0, 8'd0, 8'd21, 8'd12});
    chk("udf_lane1", {48'd0, win_out[47:24]}, {48'd0, 8'd31, 8'd22, 8'd21});
    chk("udf_flag", {70'd0, err_ovf, err_udf}, 72'd1);
    drive(6'b111111, 24'd0, 0, 1);
    step;
    chk("ena_hi", {71'd0, win_valid}, 72'd1);
    drive(6'b111111, 24'd0, 0, 0);
    step;
    chk("ena_lo", {71'd0, win_valid}, 72'd0);
    chk("udf_sticky", {71'd0, err_udf}, 72'd1);

    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("midrst_win", win_out, '0);
    chk("midrst_emp", {69'd0, fq_empty}, 72'd7);
    chk("midrst_err", {70'd0, err_ovf, err_udf}, 72'd0);

    for (int n = 0; n < 8; n++) begin
      drive(6'b110011, bp3(0, 51 + n, 0), 0, 0);
      step;
    end
    chk("fill_emp", {69'd0, fq_empty}, 72'd6);
    chk("fill_noovf", {71'd0, err_ovf}, 72'd0);
    drive(6'b110011, bp3(0, 60, 0), 1, 0);
    step;
    chk("full_pushpop", {71'd0, err_ovf}, 72'd0);
    drive(6'b110011, bp3(0, 61, 0), 0, 0);
    step;
    chk("ovf_flag", {71'd0, err_ovf}, 72'd1);
    drive(6'b111110, 24'd0, 0, 0);
    step;
    chk("drain_51", {64'd0, win_out[23:16]}, 72'd51);
    for (int n = 0; n < 8; n++) begin
      int e;
      e = (n < 7) ? 52 + n : 60;
      drive(6'b111111, 24'd0, 1, 0);
      step;
      drive(6'b111110, 24'd0, 0, 0);
      step;
      chk($sformatf("drain_%0d", n), {64'd0, win_out[23:16]}, 72'(e));
    end
    chk("drain_emp", {69'd0, fq_empty}, 72'd7);
    drive(6'b111111, 24'd0, 1, 0);
    step;
    chk("empty_read", {69'd0, fq_empty}, 72'd7);
    chk("final_err", {70'd0, err_ovf, err_udf}, 72'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
